// File: rtl/grid_pkg.sv
// grid_pkg: shared state encoding, board and geometry constants
// for the 4x4 2048 board renderer.
package grid_pkg;
  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_DRAW,
    S_DONE
  } state_e;

  localparam int NUM_BOXES = 16;
  localparam int VAL_W     = 4;

  localparam int         DEF_X_ORIGIN  = 57;
  localparam int         DEF_Y_ORIGIN  = 27;
  localparam int         DEF_BOX_SIZE  = 15;
  localparam int         DEF_BOX_PITCH = 17;
  localparam logic [2:0] DEF_BORDER    = 3'b100;
endpackage

// File: rtl/tile_colour.sv
// tile_colour: pixel colour of a tile from its exponent and the
// pixel position inside the box (border plus 7-entry colour cycle).
module tile_colour
  import grid_pkg::*;
#(
  parameter int         BOX_SIZE      = DEF_BOX_SIZE,
  parameter logic [2:0] BORDER_COLOUR = DEF_BORDER
) (
  input  logic [VAL_W-1:0] value,
  input  logic [3:0]       px,
  input  logic [3:0]       py,
  output logic [2:0]       colour
);
  localparam logic [3:0] LAST = 4'(BOX_SIZE - 1);

  logic       on_edge;
  logic [3:0] m;

  always_comb begin
    on_edge = (px == 4'd0) || (py == 4'd0) ||
              (px == LAST) || (py == LAST);
    // (v-1) mod 7 for v in 1..15
    m = value - 4'd1;
    if (m >= 4'd14) m = m - 4'd14;
    else if (m >= 4'd7) m = m - 4'd7;
    if (on_edge) colour = BORDER_COLOUR;
    else if (value == '0) colour = 3'b000;
    else colour = 3'(m) + 3'd1;
  end
endmodule

// File: rtl/grid_draw_ctrl.sv
// grid_draw_ctrl: frame sequencer that redraws changed boxes of the
// 4x4 board as 15x15 pixel tiles on the VGA adapter plot port.
module grid_draw_ctrl
  import grid_pkg::*;
#(
  parameter int         X_ORIGIN      = DEF_X_ORIGIN,
  parameter int         Y_ORIGIN      = DEF_Y_ORIGIN,
  parameter int         BOX_SIZE      = DEF_BOX_SIZE,
  parameter int         BOX_PITCH     = DEF_BOX_PITCH,
  parameter logic [2:0] BORDER_COLOUR = DEF_BORDER
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        full_redraw,
  input  logic [63:0] values,
  output logic        busy,
  output logic        done,
  output logic        plot,
  output logic [6:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour
);
  localparam logic [6:0] X0    = 7'(X_ORIGIN);
  localparam logic [6:0] Y0    = 7'(Y_ORIGIN);
  localparam logic [6:0] PITCH = 7'(BOX_PITCH);
  localparam logic [3:0] PLAST = 4'(BOX_SIZE - 1);
  localparam logic [3:0] BLAST = 4'(NUM_BOXES - 1);

  state_e      state_q, state_d;
  logic [3:0]  box_q, box_d;
  logic [3:0]  px_q, px_d;
  logic [3:0]  py_q, py_d;
  logic [63:0] snap_q, snap_d;
  logic [63:0] last_q, last_d;
  logic        force_q, force_d;
  logic        pending_q, pending_d;
  logic        pforce_q, pforce_d;
  logic        all_dirty_q, all_dirty_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        plot_q, plot_d;
  logic [6:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;

  logic [5:0]  lsb;
  logic [3:0]  cur_val;
  logic [3:0]  old_val;
  logic [2:0]  pix_colour;
  logic        dirty;
  logic        begin_frame;

  assign lsb     = {box_q, 2'b00};
  assign cur_val = snap_q[lsb +: 4];
  assign old_val = last_q[lsb +: 4];
  assign dirty   = force_q | (cur_val != old_val);

  tile_colour #(
    .BOX_SIZE      (BOX_SIZE),
    .BORDER_COLOUR (BORDER_COLOUR)
  ) u_colour (
    .value  (cur_val),
    .px     (px_q),
    .py     (py_q),
    .colour (pix_colour)
  );

  always_comb begin
    state_d     = state_q;
    box_d       = box_q;
    px_d        = px_q;
    py_d        = py_q;
    snap_d      = snap_q;
    last_d      = last_q;
    force_d     = force_q;
    pending_d   = pending_q;
    pforce_d    = pforce_q;
    all_dirty_d = all_dirty_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    plot_d      = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    begin_frame = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin_frame = 1'b1;
      end
      S_SELECT: begin
        if (dirty) state_d = S_DRAW;
        else if (box_q == BLAST) state_d = S_DONE;
        else box_d = box_q + 4'd1;
      end
      S_DRAW: begin
        plot_d   = 1'b1;
        x_d      = X0 + 7'(box_q[1:0]) * PITCH + 7'(px_q);
        y_d      = Y0 + 7'(box_q[3:2]) * PITCH + 7'(py_q);
        colour_d = pix_colour;
        px_d     = px_q + 4'd1;
        if (px_q == PLAST) begin
          px_d = '0;
          py_d = py_q + 4'd1;
          if (py_q == PLAST) begin
            py_d = '0;
            last_d[lsb +: 4] = cur_val;
            if (box_q == BLAST) begin
              state_d = S_DONE;
            end else begin
              box_d   = box_q + 4'd1;
              state_d = S_SELECT;
            end
          end
        end
      end
      S_DONE: begin
        done_d      = 1'b1;
        all_dirty_d = 1'b0;
        if (pending_q || start) begin
          begin_frame = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase

    // a request during a frame is replayed when the frame ends
    if ((state_q == S_SELECT || state_q == S_DRAW) && start) begin
      pending_d = 1'b1;
      pforce_d  = pforce_q | full_redraw;
    end

    if (begin_frame) begin
      snap_d    = values;
      force_d   = (start & full_redraw) | pforce_q | all_dirty_q;
      box_d     = '0;
      px_d      = '0;
      py_d      = '0;
      pending_d = 1'b0;
      pforce_d  = 1'b0;
      busy_d    = 1'b1;
      state_d   = S_SELECT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      box_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      snap_q      <= '0;
      last_q      <= '0;
      force_q     <= 1'b0;
      pending_q   <= 1'b0;
      pforce_q    <= 1'b0;
      all_dirty_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      plot_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
    end else begin
      state_q     <= state_d;
      box_q       <= box_d;
      px_q        <= px_d;
      py_q        <= py_d;
      snap_q      <= snap_d;
      last_q      <= last_d;
      force_q     <= force_d;
      pending_q   <= pending_d;
      pforce_q    <= pforce_d;
      all_dirty_q <= all_dirty_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      plot_q      <= plot_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign plot   = plot_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
endmodule

// File: tb/tb_grid_draw_ctrl.sv
// tb_grid_draw_ctrl: randomized frames checked against a frame-level
// pixel-list model of the board renderer.
module tb_grid_draw_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        full_redraw = 1'b0;
  logic [63:0] values = '0;
  logic        busy, done, plot;
  logic [6:0]  x, y;
  logic [2:0]  colour;

  grid_draw_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .full_redraw (full_redraw),
    .values      (values),
    .busy        (busy),
    .done        (done),
    .plot        (plot),
    .x           (x),
    .y           (y),
    .colour      (colour)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [3:0]  last_m [16];
  bit          all_dirty_m, active_m, pend_m, pforce_m, mon_en;
  logic [16:0] exp_q [$];
  int          cyc, acc_cyc, exp_lat, plots, exp_plots;
  logic [16:0] first_px, last_px;

  function automatic logic [2:0] ref_colour(int v, int px, int py);
    if (px == 0 || py == 0 || px == 14 || py == 14) return 3'b100;
    if (v == 0) return 3'b000;
    return 3'((v - 1) % 7 + 1);
  endfunction

  task automatic start_model(input logic [63:0] snap, input bit frc);
    int n = 0;
    for (int b = 0; b < 16; b++) begin
      int v = int'(snap[4*b +: 4]);
      if (frc || v != int'(last_m[b])) begin
        n++;
        last_m[b] = 4'(v);
        for (int py = 0; py < 15; py++)
          for (int px = 0; px < 15; px++)
            exp_q.push_back({7'(57 + (b % 4) * 17 + px),
                             7'(27 + (b / 4) * 17 + py),
                             ref_colour(v, px, py)});
      end
    end
    acc_cyc   = cyc;
    exp_lat   = 17 + 225 * n;
    exp_plots = 225 * n;
    plots     = 0;
    active_m  = 1;
    pend_m    = 0;
    pforce_m  = 0;
  endtask

  always @(posedge clock) begin
    logic        s_st, s_fr, s_rst;
    logic [63:0] s_val;
    bit          old_ad;
    s_st  = start;
    s_fr  = full_redraw;
    s_rst = reset;
    s_val = values;
    cyc++;
    #1;
    if (s_rst) begin
      mon_en = 1;
      active_m = 0;
      pend_m = 0;
      pforce_m = 0;
      all_dirty_m = 1;
      exp_q.delete();
      for (int b = 0; b < 16; b++) last_m[b] = '0;
      check("rst_plot", plot, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end else if (mon_en) begin
      if (plot) begin
        if (exp_q.size() == 0) check("extra_plot", plot, 0);
        else check("pixel", {x, y, colour}, exp_q.pop_front());
        if (plots == 0) first_px = {x, y, colour};
        last_px = {x, y, colour};
        plots++;
      end
      if (done) begin
        check("done_lat", cyc - acc_cyc, exp_lat);
        check("frame_plots", plots, exp_plots);
        check("queue_left", exp_q.size(), 0);
        old_ad = all_dirty_m;
        all_dirty_m = 0;
        if (pend_m || s_st)
          start_model(s_val, pforce_m | (s_st & s_fr) | old_ad);
        else
          active_m = 0;
      end else if (s_st) begin
        if (!active_m) start_model(s_val, s_fr | all_dirty_m);
        else begin
          pend_m = 1;
          pforce_m = pforce_m | s_fr;
        end
      end
      check("busy", busy, active_m);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start(input bit fr);
    start = 1;
    full_redraw = fr;
    @(negedge clock);
    start = 0;
    full_redraw = 0;
  endtask

  task automatic wait_done(input int limit);
    int k = 1;
    @(negedge clock);
    while (done !== 1'b1 && k < limit) begin
      @(negedge clock);
      k++;
    end
    if (done !== 1'b1) check("done_timeout", done, 1);
  endtask

  initial begin
    @(negedge clock);
    reset = 1;
    tick(3);
    reset = 0;
    tick(2);
    check("idle_busy", busy, 0);
    check("idle_plot", plot, 0);

    values = '0;
    pulse_start(0);
    wait_done(5000);
    check("t1_plots", plots, 3600);
    check("t1_first", first_px, {7'd57, 7'd27, 3'b100});
    check("t1_last", last_px, {7'd122, 7'd92, 3'b100});
    tick(2);

    pulse_start(0);
    wait_done(100);
    check("t2_plots", plots, 0);
    tick(2);

    values[23:20] = 4'd3;
    pulse_start(0);
    wait_done(500);
    check("t3_plots", plots, 225);
    check("t3_first", first_px, {7'd74, 7'd44, 3'b100});
    check("t3_last", last_px, {7'd88, 7'd58, 3'b100});
    tick(2);

    values = {$urandom, $urandom};
    pulse_start(1);
    tick($urandom_range(20, 3000));
    pulse_start(1'($urandom_range(0, 1)));
    values = {$urandom, $urandom};
    wait_done(5000);
    check("t4_busy_restart", busy, 1);
    wait_done(5000);
    tick(2);
    check("t4_idle", busy, 0);

    pulse_start(1);
    tick(7 * 226 + 60);
    reset = 1;
    tick(1);
    reset = 0;
    check("t5_plot", plot, 0);
    check("t5_busy", busy, 0);
    tick(2);
    pulse_start(0);
    wait_done(5000);
    check("t5_plots", plots, 3600);
    tick(2);

    values = {$urandom, $urandom};
    values[3:0] = 4'd8;
    values[7:4] = 4'd15;
    pulse_start(1);
    wait_done(5000);
    check("t6_plots", plots, 3600);
    tick(2);

    for (int i = 0; i < 6; i++) begin
      int nb = $urandom_range(0, 4);
      for (int j = 0; j < nb; j++) begin
        int b = $urandom_range(0, 15);
        values[4*b +: 4] = 4'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        pulse_start(1);
        tick($urandom_range(5, 200));
        pulse_start(0);
        values = {$urandom, $urandom};
        wait_done(5000);
        wait_done(5000);
      end else begin
        pulse_start(1'($urandom_range(0, 3) == 0));
        wait_done(5000);
      end
      tick($urandom_range(1, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
